// File: rtl/muntjac_perf_counters_pkg.sv
// Shared CSR encodings and constants for the machine performance counter block.
package muntjac_perf_counters_pkg;

    // CSR numbers owned by (or adjacent to) the performance counter block. The hpm ranges
    // are addressed as base + index; only the first entry of each range is named here.
    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MHPMEVENT3    = 12'h323,
        CSR_MCYCLE        = 12'hB00,
        CSR_MINSTRET      = 12'hB02,
        CSR_MHPMCOUNTER3  = 12'hB03,
        CSR_CYCLE         = 12'hC00,
        CSR_TIME          = 12'hC01,
        CSR_INSTRET       = 12'hC02,
        CSR_HPMCOUNTER3   = 12'hC03
    } csr_num_e;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } priv_lvl_e;

    localparam int unsigned CSR_MCOUNTINHIBIT_CY_BIT = 0;
    localparam int unsigned CSR_MCOUNTINHIBIT_IR_BIT = 2;
    localparam int unsigned HPM_COUNTER_BASE         = 3;
    localparam int unsigned HPM_COUNTER_MAX          = 29;

    // Upper seven address bits of each 32-entry CSR page this block decodes.
    localparam logic [6:0] CSR_MCNT_PAGE = 7'h58;  // 0xB00..0xB1F
    localparam logic [6:0] CSR_UCNT_PAGE = 7'h60;  // 0xC00..0xC1F
    localparam logic [6:0] CSR_MCFG_PAGE = 7'h19;  // 0x320..0x33F

    // New CSR value for a read-modify-write op; READ returns the old value unchanged.
    function automatic logic [63:0] csr_write_value(csr_op_e op, logic [63:0] old_val,
                                                    logic [63:0] wdata);
        logic [63:0] result;
        unique case (op)
            CSR_OP_WRITE: result = wdata;
            CSR_OP_SET:   result = old_val | wdata;
            CSR_OP_CLEAR: result = old_val & ~wdata;
            default:      result = old_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/muntjac_perf_counter.sv
// One 64-bit wrapping event counter; a write in the same cycle replaces the increment.
module muntjac_perf_counter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        inhibit_i,
    input  logic        wr_en_i,
    input  logic [63:0] wr_data_i,
    output logic [63:0] value_o
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // Next count: write has priority, otherwise count unless inhibited.
    always_comb begin
        count_d = count_q;
        if (wr_en_i) begin
            count_d = wr_data_i;
        end else if (inc_i && !inhibit_i) begin
            count_d = count_q + 64'd1;
        end
    end

    // Counter state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value_o = count_q;

endmodule

// File: rtl/muntjac_perf_counters.sv
// Machine performance counters: CSR decode, counter-enable checks, event selectors,
// mcountinhibit and the registered CSR response.
module muntjac_perf_counters
    import muntjac_perf_counters_pkg::*;
#(
    parameter int unsigned HpmCounterNum = 4,
    parameter int unsigned HpmEventNum   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   csr_valid_i,
    input  logic [11:0]            csr_addr_i,
    input  logic [1:0]             csr_op_i,
    input  logic [63:0]            csr_wdata_i,
    input  logic [1:0]             priv_lvl_i,
    input  logic [31:0]            mcounteren_i,
    input  logic [31:0]            scounteren_i,
    input  logic                   instret_i,
    input  logic [HpmEventNum-1:0] hpm_event_i,
    output logic                   rsp_valid_o,
    output logic                   rsp_hit_o,
    output logic                   rsp_illegal_o,
    output logic [63:0]            rsp_rdata_o
);

    // Counter slots: 0 = mcycle, 1 = minstret, 2+k = mhpmcounter(3+k).
    localparam int unsigned NumCnt = 2 + HpmCounterNum;

    // Writable mcountinhibit bits: CY, IR and one per implemented hpm counter.
    localparam logic [31:0] InhibitMask =
        (32'd1 << CSR_MCOUNTINHIBIT_CY_BIT) |
        (32'd1 << CSR_MCOUNTINHIBIT_IR_BIT) |
        (((32'd1 << HpmCounterNum) - 32'd1) << HPM_COUNTER_BASE);

    csr_op_e   op;
    priv_lvl_e priv;
    logic [4:0]  idx;
    logic [31:0] idx_w;
    logic in_mcnt;
    logic in_ucnt;
    logic in_mcfg;
    logic hit;
    logic illegal;
    logic cen_ok;
    logic do_write;
    logic [63:0] rd_val;
    logic [63:0] wr_val;

    logic [63:0]        cnt_val [NumCnt];
    logic [NumCnt-1:0]  cnt_inc;
    logic [NumCnt-1:0]  cnt_inh;
    logic [NumCnt-1:0]  cnt_wr;

    logic [31:0]              inhibit_q;
    logic [HpmEventNum-1:0]   mhpmevent_q [HpmCounterNum];
    logic                     inhibit_wr;
    logic [HpmCounterNum-1:0] event_wr;

    logic        rsp_valid_q;
    logic        rsp_hit_q;
    logic        rsp_illegal_q;
    logic [63:0] rsp_rdata_q;

    assign op    = csr_op_e'(csr_op_i);
    assign priv  = priv_lvl_e'(priv_lvl_i);
    assign idx   = csr_addr_i[4:0];
    assign idx_w = {27'd0, idx};

    // Address decode, privilege / counter-enable check and illegal flag.
    always_comb begin
        in_mcnt = (csr_addr_i[11:5] == CSR_MCNT_PAGE);
        in_ucnt = (csr_addr_i[11:5] == CSR_UCNT_PAGE);
        in_mcfg = (csr_addr_i[11:5] == CSR_MCFG_PAGE);

        // Index 1 of the counter pages is time / an unused slot and belongs elsewhere;
        // indices 1 and 2 of the config page are not counter CSRs.
        hit = 1'b0;
        if (in_mcnt || in_ucnt) begin
            hit = (idx != 5'd1);
        end else if (in_mcfg) begin
            hit = (idx == 5'd0) || (idx_w >= HPM_COUNTER_BASE);
        end

        case (priv)
            PRIV_LVL_M: cen_ok = 1'b1;
            PRIV_LVL_U: cen_ok = mcounteren_i[idx] & scounteren_i[idx];
            default:    cen_ok = mcounteren_i[idx];
        endcase

        illegal = hit & ((((in_mcnt | in_mcfg) & (priv != PRIV_LVL_M))) |
                         (in_ucnt & ((op != CSR_OP_READ) | ~cen_ok)));

        do_write = csr_valid_i & hit & ~illegal & (op != CSR_OP_READ);
    end

    // Old CSR value; unimplemented hpm slots read as zero.
    always_comb begin
        rd_val = '0;
        if (in_mcnt || in_ucnt) begin
            if (idx == 5'd0) rd_val = cnt_val[0];
            if (idx == 5'd2) rd_val = cnt_val[1];
            for (int unsigned k = 0; k < HpmCounterNum; k++) begin
                if (idx_w == k + HPM_COUNTER_BASE) rd_val = cnt_val[k+2];
            end
        end else if (in_mcfg) begin
            if (idx == 5'd0) rd_val = {32'd0, inhibit_q};
            for (int unsigned k = 0; k < HpmCounterNum; k++) begin
                if (idx_w == k + HPM_COUNTER_BASE) rd_val = 64'(mhpmevent_q[k]);
            end
        end
    end

    assign wr_val = csr_write_value(op, rd_val, csr_wdata_i);

    // Per-counter write strobes, increment requests and inhibit bits.
    always_comb begin
        cnt_wr     = '0;
        event_wr   = '0;
        inhibit_wr = 1'b0;

        // User mirrors never reach here: any write to them is illegal.
        if (do_write && in_mcnt) begin
            if (idx == 5'd0) cnt_wr[0] = 1'b1;
            if (idx == 5'd2) cnt_wr[1] = 1'b1;
            for (int unsigned k = 0; k < HpmCounterNum; k++) begin
                if (idx_w == k + HPM_COUNTER_BASE) cnt_wr[k+2] = 1'b1;
            end
        end
        if (do_write && in_mcfg) begin
            if (idx == 5'd0) inhibit_wr = 1'b1;
            for (int unsigned k = 0; k < HpmCounterNum; k++) begin
                if (idx_w == k + HPM_COUNTER_BASE) event_wr[k] = 1'b1;
            end
        end

        cnt_inc[0] = 1'b1;
        cnt_inh[0] = inhibit_q[CSR_MCOUNTINHIBIT_CY_BIT];
        cnt_inc[1] = instret_i;
        cnt_inh[1] = inhibit_q[CSR_MCOUNTINHIBIT_IR_BIT];
        for (int unsigned k = 0; k < HpmCounterNum; k++) begin
            cnt_inc[k+2] = |(hpm_event_i & mhpmevent_q[k]);
            cnt_inh[k+2] = inhibit_q[k+HPM_COUNTER_BASE];
        end
    end

    for (genvar g = 0; g < NumCnt; g++) begin : g_cnt
        muntjac_perf_counter u_cnt (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .inc_i     (cnt_inc[g]),
            .inhibit_i (cnt_inh[g]),
            .wr_en_i   (cnt_wr[g]),
            .wr_data_i (wr_val),
            .value_o   (cnt_val[g])
        );
    end

    // mcountinhibit and mhpmevent selector registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inhibit_q <= '0;
            for (int unsigned k = 0; k < HpmCounterNum; k++) begin
                mhpmevent_q[k] <= '0;
            end
        end else begin
            if (inhibit_wr) inhibit_q <= wr_val[31:0] & InhibitMask;
            for (int unsigned k = 0; k < HpmCounterNum; k++) begin
                if (event_wr[k]) mhpmevent_q[k] <= wr_val[HpmEventNum-1:0];
            end
        end
    end

    // Registered response; data is zeroed for misses and illegal accesses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q   <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            rsp_valid_q   <= csr_valid_i;
            rsp_hit_q     <= csr_valid_i & hit;
            rsp_illegal_q <= csr_valid_i & illegal;
            rsp_rdata_q   <= (csr_valid_i & hit & ~illegal) ? rd_val : '0;
        end
    end

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_hit_o     = rsp_hit_q;
    assign rsp_illegal_o = rsp_illegal_q;
    assign rsp_rdata_o   = rsp_rdata_q;

endmodule
